// File: rtl/muntjac_pkg.sv
// Shared definitions for the Muntjac instruction-fetch blocks.
package muntjac_pkg;

  // Reason attached to each fetch request by the frontend.
  typedef enum logic [3:0] {
    IF_PREFETCH     = 4'h0,
    IF_MISPREDICT   = 4'h1,
    IF_PROT_CHANGED = 4'h2,
    IF_SATP_CHANGED = 4'h3,
    IF_FENCE_I      = 4'h4
  } if_reason_e;

  // satp/atp MODE field value meaning "no translation".
  localparam logic [3:0] ATP_MODE_BARE = 4'd0;

  // Line-buffer controller states.
  typedef enum logic [2:0] {
    IDLE,
    HIT,
    FAULT,
    MREQ,
    MWAIT,
    MRESP
  } ifetch_lb_state_e;

endpackage

// File: rtl/muntjac_ifetch_linebuf_store.sv
// Single-line instruction store: beat-wide data array, tag and valid bit,
// with a 32-bit word read mux and a tag-match lookup.
module muntjac_ifetch_linebuf_store #(
  parameter int unsigned LineBeatsLog2 = 2,
  parameter int unsigned PhysAddrWidth = 56
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  // Beat write port used during refill.
  input  logic                                   wr_en_i,
  input  logic [LineBeatsLog2-1:0]               wr_idx_i,
  input  logic [63:0]                            wr_data_i,
  // Tag/valid update at the end of a refill.
  input  logic                                   tag_wr_en_i,
  input  logic [PhysAddrWidth-LineBeatsLog2-4:0] tag_i,
  input  logic                                   valid_i,
  // Invalidate takes priority over a tag update.
  input  logic                                   inv_i,
  // Lookup and word read.
  input  logic [PhysAddrWidth-LineBeatsLog2-4:0] lookup_tag_i,
  output logic                                   hit_o,
  input  logic [LineBeatsLog2:0]                 rd_word_i,
  output logic [31:0]                            rd_word_o
);

  logic [63:0]                            r_data [0:(1 << LineBeatsLog2)-1];
  logic [PhysAddrWidth-LineBeatsLog2-4:0] r_tag;
  logic                                   r_valid;
  logic [63:0]                            w_beat;

  // Line data has no reset; it is only read once the valid bit says so.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_data[wr_idx_i] <= wr_data_i;
  end

  // Tag and valid bit; invalidation wins over a simultaneous update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (inv_i) begin
      r_valid <= 1'b0;
    end else if (tag_wr_en_i) begin
      r_valid <= valid_i;
      r_tag   <= tag_i;
    end
  end

  // Word mux: upper index bits pick the beat, bit 0 picks the half.
  always_comb begin
    w_beat    = r_data[rd_word_i[LineBeatsLog2:1]];
    rd_word_o = rd_word_i[0] ? w_beat[63:32] : w_beat[31:0];
    hit_o     = r_valid && (r_tag == lookup_tag_i);
  end

endmodule

// File: rtl/muntjac_ifetch_linebuf.sv
// Minimal non-paging instruction cache: one line buffer refilled by a burst
// read. Serves one request at a time and answers each with exactly one
// resp_valid_o pulse.
//
// Handshakes: req_valid_i and resp_valid_o are single-cycle strobes with no
// back-pressure; mem_req_valid_o is held with a stable address until it is
// seen together with mem_req_ready_i on a rising edge; mem_resp_valid_i marks
// one 64-bit beat per cycle, in ascending address order, and is only legal
// while a refill is in progress.
module muntjac_ifetch_linebuf
  import muntjac_pkg::*;
#(
  parameter int unsigned LineBeatsLog2 = 2,
  parameter int unsigned PhysAddrWidth = 56
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  input  logic [63:0]              req_pc_i,
  input  logic [3:0]               req_reason_i,
  input  logic [63:0]              req_atp_i,
  input  logic                     req_prv_i,
  input  logic                     req_sum_i,
  output logic                     resp_valid_o,
  output logic [31:0]              resp_instr_o,
  output logic                     resp_exception_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [PhysAddrWidth-1:0] mem_req_addr_o,
  input  logic                     mem_resp_valid_i,
  input  logic [63:0]              mem_resp_data_i,
  input  logic                     mem_resp_error_i,
  output ifetch_lb_state_e         dbg_state_o
);

  localparam int unsigned LB = LineBeatsLog2;
  localparam int unsigned PA = PhysAddrWidth;

  ifetch_lb_state_e  r_state;
  logic              r_resp_valid;
  logic [31:0]       r_resp_instr;
  logic              r_resp_exc;
  logic              r_mem_req_valid;
  logic [PA-1:0]     r_mem_addr;
  logic [PA-LB-4:0]  r_tag;
  logic [LB:0]       r_word;
  logic [LB-1:0]     r_cnt;
  logic              r_err;

  logic              w_accept;
  logic              w_fence;
  logic              w_bare;
  logic              w_store_hit;
  logic              w_hit;
  logic              w_inv;
  logic              w_beat_we;
  logic              w_last_beat;
  logic              w_err_acc;
  logic [LB:0]       w_rd_idx;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_fwd_word;
  logic [31:0]       w_fill_word;
  logic              w_unused;

  // Privilege, SUM and the non-mode atp bits play no part in a bare fetch.
  assign w_unused = ^{req_prv_i, req_sum_i, req_atp_i[59:0],
                      req_pc_i[63:PA], req_pc_i[1:0]};

  // Request decode and lookup; a FENCE_I never hits because the line is
  // invalidated on the same edge the request is accepted.
  always_comb begin
    w_accept    = (r_state == IDLE) && req_valid_i;
    w_fence     = (req_reason_i == IF_FENCE_I);
    w_bare      = (req_atp_i[63:60] == ATP_MODE_BARE);
    w_hit       = w_store_hit && !w_fence;
    w_inv       = w_accept && (w_fence || (w_bare && !w_hit));
    w_beat_we   = (r_state == MWAIT) && mem_resp_valid_i;
    w_last_beat = (r_cnt == '1);
    w_err_acc   = r_err | mem_resp_error_i;
    w_rd_idx    = (r_state == IDLE) ? req_pc_i[LB+2:2] : r_word;
    // The final beat is still on the bus when the response is registered,
    // so forward it if it holds the requested word.
    w_fwd_word  = r_word[0] ? mem_resp_data_i[63:32] : mem_resp_data_i[31:0];
    w_fill_word = (r_word[LB:1] == r_cnt) ? w_fwd_word : w_rd_word;
  end

  muntjac_ifetch_linebuf_store #(
    .LineBeatsLog2 (LB),
    .PhysAddrWidth (PA)
  ) u_store (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_en_i      (w_beat_we),
    .wr_idx_i     (r_cnt),
    .wr_data_i    (mem_resp_data_i),
    .tag_wr_en_i  (r_state == MRESP),
    .tag_i        (r_tag),
    .valid_i      (!r_err),
    .inv_i        (w_inv),
    .lookup_tag_i (req_pc_i[PA-1:LB+3]),
    .hit_o        (w_store_hit),
    .rd_word_i    (w_rd_idx),
    .rd_word_o    (w_rd_word)
  );

  // Controller FSM; response and memory-request outputs are registered so
  // that resp_valid_o is high exactly while in HIT, FAULT or MRESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_resp_valid    <= 1'b0;
      r_resp_instr    <= '0;
      r_resp_exc      <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_tag           <= '0;
      r_word          <= '0;
      r_cnt           <= '0;
      r_err           <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_word <= req_pc_i[LB+2:2];
            if (!w_bare) begin
              r_state      <= FAULT;
              r_resp_valid <= 1'b1;
              r_resp_exc   <= 1'b1;
              r_resp_instr <= '0;
            end else if (w_hit) begin
              r_state      <= HIT;
              r_resp_valid <= 1'b1;
              r_resp_exc   <= 1'b0;
              r_resp_instr <= w_rd_word;
            end else begin
              r_state         <= MREQ;
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= {req_pc_i[PA-1:LB+3], {(LB+3){1'b0}}};
              r_tag           <= req_pc_i[PA-1:LB+3];
            end
          end
        end
        HIT, FAULT: begin
          r_state <= IDLE;
        end
        MREQ: begin
          if (mem_req_ready_i) begin
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_err           <= 1'b0;
            r_state         <= MWAIT;
          end
        end
        MWAIT: begin
          if (mem_resp_valid_i) begin
            r_cnt <= r_cnt + LB'(1);
            r_err <= w_err_acc;
            if (w_last_beat) begin
              r_state      <= MRESP;
              r_resp_valid <= 1'b1;
              r_resp_exc   <= w_err_acc;
              r_resp_instr <= w_err_acc ? 32'h0 : w_fill_word;
            end
          end
        end
        MRESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid_o     = r_resp_valid;
  assign resp_instr_o     = r_resp_instr;
  assign resp_exception_o = r_resp_exc;
  assign mem_req_valid_o  = r_mem_req_valid;
  assign mem_req_addr_o   = r_mem_addr;
  assign dbg_state_o      = r_state;

  // Protocol checks: one request at a time, beats only during a refill.
  a_req_only_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    req_valid_i |-> (r_state == IDLE));
  a_beat_only_mwait: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_resp_valid_i |-> (r_state == MWAIT));
  a_prv_known: assert property (@(posedge clk_i) disable iff (rst_i)
    req_valid_i |-> !$isunknown(req_prv_i));

endmodule

// File: tb/tb_muntjac_ifetch_linebuf.sv
// Directed bench for muntjac_ifetch_linebuf: a table of fetch requests with
// hand-computed responses, served by a small in-bench memory, plus a
// reset-during-refill sequence.
module tb_muntjac_ifetch_linebuf;
  import muntjac_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [63:0] req_pc_i;
  logic [3:0]  req_reason_i;
  logic [63:0] req_atp_i;
  logic        req_prv_i;
  logic        req_sum_i;
  logic        resp_valid_o;
  logic [31:0] resp_instr_o;
  logic        resp_exception_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [55:0] mem_req_addr_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_resp_data_i;
  logic        mem_resp_error_i;
  ifetch_lb_state_e dbg_state_o;

  always #5 clk = ~clk;

  muntjac_ifetch_linebuf #(
    .LineBeatsLog2 (2),
    .PhysAddrWidth (56)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid_i),
    .req_pc_i         (req_pc_i),
    .req_reason_i     (req_reason_i),
    .req_atp_i        (req_atp_i),
    .req_prv_i        (req_prv_i),
    .req_sum_i        (req_sum_i),
    .resp_valid_o     (resp_valid_o),
    .resp_instr_o     (resp_instr_o),
    .resp_exception_o (resp_exception_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .mem_resp_error_i (mem_resp_error_i),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];   // {exception, instr}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  // Line 0x1000 generation 0 holds a hand-written instruction image; every
  // other line/generation holds word k = line + gen*0x10000 + k.
  function automatic logic [63:0] mem_beat(input logic [55:0] line, input int b, input int gen);
    logic [31:0] base;
    if (line == 56'h1000 && gen == 0) begin
      case (b)
        0:       return 64'h0000_0013_0000_0093;
        1:       return 64'h0000_0213_0000_0113;
        2:       return 64'h0000_0413_0000_0313;
        default: return 64'h0000_0613_0000_0513;
      endcase
    end
    base = line[31:0] + 32'(gen) * 32'h0001_0000;
    return {base + 32'(2*b+1), base + 32'(2*b)};
  endfunction

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  reason;
    logic [63:0] atp;
    int          gen;
    int          err_beat;
    int          ready_dly;
    logic        exp_miss;
    logic [55:0] exp_addr;
    logic [31:0] exp_instr;
    logic        exp_exc;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] pc, input logic [3:0] reason,
                              input logic [63:0] atp, input int gen, input int err_beat,
                              input int ready_dly, input logic exp_miss,
                              input logic [55:0] exp_addr, input logic [31:0] exp_instr,
                              input logic exp_exc);
    vec_t v;
    v.pc = pc; v.reason = reason; v.atp = atp; v.gen = gen; v.err_beat = err_beat;
    v.ready_dly = ready_dly; v.exp_miss = exp_miss; v.exp_addr = exp_addr;
    v.exp_instr = exp_instr; v.exp_exc = exp_exc;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Issues one request, then serves the memory side cycle by cycle and
  // records the response; runs two cycles past the response to catch
  // duplicate pulses.
  task automatic run_vec(input vec_t v, input string tag);
    int          resp_cyc = 0;
    int          last_beat_cyc = -10;
    int          n_resp = 0;
    int          n_req_acc = 0;
    int          n_req_cyc = 0;
    int          wait_cnt = 0;
    int          beat = 0;
    bit          sending = 0;
    bit          addr_stable = 1;
    logic [55:0] first_addr = '0;
    logic [31:0] got_instr = 32'hdead_beef;
    logic        got_exc = 1'b0;
    logic [32:0] exp;

    exp_q.push_back({v.exp_exc, v.exp_instr});
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_pc_i     = v.pc;
    req_reason_i = v.reason;
    req_atp_i    = v.atp;
    @(negedge clk);
    req_valid_i  = 1'b0;
    req_reason_i = IF_PREFETCH;
    req_atp_i    = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (resp_valid_o) begin
        n_resp++;
        if (n_resp == 1) begin
          resp_cyc  = cyc;
          got_instr = resp_instr_o;
          got_exc   = resp_exception_o;
        end
      end
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b0;
      mem_resp_error_i = 1'b0;
      mem_resp_data_i  = '0;
      if (mem_req_valid_o) begin
        n_req_cyc++;
        if (n_req_cyc == 1) first_addr = mem_req_addr_o;
        else if (mem_req_addr_o !== first_addr) addr_stable = 0;
        if (wait_cnt == v.ready_dly) begin
          mem_req_ready_i = 1'b1;
          n_req_acc++;
          sending = 1;
          beat    = 0;
        end else begin
          wait_cnt++;
        end
      end else if (sending && beat < 4) begin
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = mem_beat(first_addr, beat, v.gen);
        mem_resp_error_i = (beat == v.err_beat);
        beat++;
        if (beat == 4) last_beat_cyc = cyc;
      end
      if (resp_cyc > 0 && cyc >= resp_cyc + 2) break;
      @(negedge clk);
    end
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_error_i = 1'b0;

    exp = exp_q.pop_front();
    check({tag, " resp_count"}, 64'(n_resp), 64'd1);
    check({tag, " instr"}, 64'(got_instr), 64'(exp[31:0]));
    check({tag, " exception"}, 64'(got_exc), 64'(exp[32]));
    if (v.exp_miss) begin
      check({tag, " mem_addr"}, 64'(first_addr), 64'(v.exp_addr));
      check({tag, " mem_req_count"}, 64'(n_req_acc), 64'd1);
      check({tag, " mem_addr_stable"}, 64'(addr_stable), 64'd1);
      check({tag, " beats_used"}, 64'(beat), 64'd4);
      check({tag, " miss_latency"}, 64'(resp_cyc), 64'(last_beat_cyc + 1));
    end else begin
      check({tag, " no_mem_req"}, 64'(n_req_cyc), 64'd0);
      check({tag, " hit_latency"}, 64'(resp_cyc), 64'd1);
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[14];

  initial begin
    int stale;
    vecs[0]  = mk(64'h1000, IF_PREFETCH, 64'h0, 0, -1, 0, 1'b1, 56'h1000, 32'h0000_0093, 1'b0);
    vecs[1]  = mk(64'h1004, IF_PREFETCH, 64'h0, 0, -1, 0, 1'b0, 56'h0,    32'h0000_0013, 1'b0);
    vecs[2]  = mk(64'h100A, IF_PREFETCH, 64'h0, 0, -1, 0, 1'b0, 56'h0,    32'h0000_0113, 1'b0);
    vecs[3]  = mk(64'h101C, IF_PREFETCH, 64'h0, 0, -1, 0, 1'b0, 56'h0,    32'h0000_0613, 1'b0);
    vecs[4]  = mk(64'h101E, IF_MISPREDICT, 64'h0, 0, -1, 0, 1'b0, 56'h0,  32'h0000_0613, 1'b0);
    vecs[5]  = mk(64'h1004, IF_FENCE_I, 64'h0, 1, -1, 2, 1'b1, 56'h1000,  32'h0001_1001, 1'b0);
    vecs[6]  = mk(64'h1008, IF_PREFETCH, 64'h0, 1, -1, 0, 1'b0, 56'h0,    32'h0001_1002, 1'b0);
    vecs[7]  = mk(64'h2000, IF_PREFETCH, 64'h0, 0,  2, 1, 1'b1, 56'h2000, 32'h0,         1'b1);
    vecs[8]  = mk(64'h2000, IF_PREFETCH, 64'h0, 0, -1, 0, 1'b1, 56'h2000, 32'h0000_2000, 1'b0);
    vecs[9]  = mk(64'h2014, IF_PREFETCH, 64'h0, 0, -1, 0, 1'b0, 56'h0,    32'h0000_2005, 1'b0);
    vecs[10] = mk(64'h2000, IF_PREFETCH, 64'h8000_0000_0000_1234, 0, -1, 0, 1'b0, 56'h0, 32'h0, 1'b1);
    vecs[11] = mk(64'h2014, IF_PREFETCH, 64'h0, 0, -1, 0, 1'b0, 56'h0,    32'h0000_2005, 1'b0);
    vecs[12] = mk(64'h1000, IF_PREFETCH, 64'h0, 0, -1, 1, 1'b1, 56'h1000, 32'h0000_0093, 1'b0);
    vecs[13] = mk(64'hFF00_0000_0000_1010, IF_PREFETCH, 64'h0, 0, -1, 0, 1'b0, 56'h0, 32'h0000_0313, 1'b0);

    rst = 1'b1;
    req_valid_i = 1'b0; req_pc_i = '0; req_reason_i = IF_PREFETCH; req_atp_i = '0;
    req_prv_i = 1'b0; req_sum_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0; mem_resp_error_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset resp_valid", 64'(resp_valid_o), 64'd0);
    check("reset resp_instr", 64'(resp_instr_o), 64'd0);
    check("reset resp_exception", 64'(resp_exception_o), 64'd0);
    check("reset mem_req_valid", 64'(mem_req_valid_o), 64'd0);
    check("reset mem_req_addr", 64'(mem_req_addr_o), 64'd0);
    check("reset state", 64'(dbg_state_o), 64'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a refill of line 0x3000 after two beats.
    @(negedge clk);
    req_valid_i = 1'b1; req_pc_i = 64'h3000;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rst_seq mem_req_valid", 64'(mem_req_valid_o), 64'd1);
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = mem_beat(56'h3000, b, 0);
      @(negedge clk);
    end
    mem_resp_valid_i = 1'b0;
    check("rst_seq in_mwait", 64'(dbg_state_o), 64'(MWAIT));
    rst = 1'b1;
    #1;
    check("rst_seq state_idle", 64'(dbg_state_o), 64'(IDLE));
    check("rst_seq resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_seq mem_req_valid", 64'(mem_req_valid_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid_o) stale++;
    end
    check("rst_seq stale_resp", 64'(stale), 64'd0);
    // Line must be invalid after reset, so 0x1000 refills again.
    run_vec(mk(64'h1000, IF_PREFETCH, 64'h0, 0, -1, 0, 1'b1, 56'h1000, 32'h0000_0093, 1'b0), "post_rst_miss");
    run_vec(mk(64'h101C, IF_PREFETCH, 64'h0, 0, -1, 0, 1'b0, 56'h0,    32'h0000_0613, 1'b0), "post_rst_hit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound in case the design stops responding altogether.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muntjac_ifetch_linebuf.md
Name: muntjac_ifetch_linebuf

Overview:
- Responder end of the instruction-cache user interface. Serves fetch requests from the frontend with a single-line instruction buffer and a burst memory refill port.
- Intended as the minimal, non-paging I$ for bring-up and small configurations.
- Returns one 32-bit aligned instruction word per request, or a fetch exception.

Parameters:
- LineBeatsLog2, 2, log2 of 64-bit beats per line; default gives a 4-beat, 32-byte line.
- PhysAddrWidth, 56, physical address width driven on the memory port.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  fetch request strobe, single-cycle.
- req_pc_i  in  64  fetch PC, 2-byte aligned.
- req_reason_i  in  4  if_reason_e.
- req_atp_i  in  64  translation register; mode in [63:60].
- req_prv_i  in  1  privilege bit; ignored except for assertion.
- req_sum_i  in  1  SUM bit; ignored.
- resp_valid_o  out  1  response strobe, single-cycle.
- resp_instr_o  out  32  word at {pc[63:2],2'b00}.
- resp_exception_o  out  1  fetch fault.
- mem_req_valid_o  out  1  line read request.
- mem_req_ready_i  in  1  request accepted.
- mem_req_addr_o  out  PhysAddrWidth  line-aligned address.
- mem_resp_valid_i  in  1  beat valid.
- mem_resp_data_i  in  64  beat data, ascending address order.
- mem_resp_error_i  in  1  bus error on this beat.

Behaviour:
Outstanding requests and reset
- At most one request outstanding. Exactly one resp_valid_o pulse per accepted request.
- req_valid_i while not IDLE is a protocol error: simulation assertion; the request is ignored.
- Reset values: resp_valid_o=0, resp_instr_o=0, resp_exception_o=0, mem_req_valid_o=0, mem_req_addr_o=0. Line valid bit=0, state IDLE, beat counter 0.

States
- IDLE, on req_valid_i:
  - If req_reason_i==IF_FENCE_I, clear the line valid bit first; the lookup then misses.
  - If req_atp_i[63:60]!=0 (paging unsupported) -> FAULT.
  - Else on hit (valid && tag==pc[PhysAddrWidth-1:LineBeatsLog2+3]) -> HIT.
  - Else -> MREQ; capture the line-aligned address.
- HIT: resp_valid_o=1, exception=0, word selected by pc[LineBeatsLog2+2:2]; -> IDLE. Hit latency is exactly 1 cycle.
- FAULT: resp_valid_o=1, resp_exception_o=1, resp_instr_o=0; -> IDLE. Latency 1; buffer untouched.
- MREQ:
  - mem_req_valid_o=1 with a stable address until mem_req_ready_i.
  - On ready -> MWAIT; clear the beat counter and the sticky error flag.
- MWAIT: on each mem_resp_valid_i:
  - Write the beat into the line at the counter index; OR the error into the sticky flag; increment the counter.
  - On the last beat (counter==2^LineBeatsLog2-1) -> MRESP.
- MRESP:
  - resp_valid_o=1. The word comes from the assembled line.
  - resp_exception_o = sticky error. On error, resp_instr_o=0.
  - Line valid = !error, tag updated; -> IDLE.
  - Miss latency = 1 + request wait + beats + 1.
- mem_resp_valid_i outside MWAIT is ignored and triggers a simulation assertion.

Boundary conditions
- Counter wraps only via the state exit and never exceeds the beat count.
- A FENCE_I request to a previously valid line always refills.
- A request for the word holding the last two bytes of a line hits on the same line; the frontend handles crossing into the next word.
- Reset mid-refill: immediately IDLE, line invalid. The memory side is reset together with this block.
- resp_instr_o and resp_exception_o hold their last values when resp_valid_o=0; consumers must qualify them with resp_valid_o.

Decomposition:
- muntjac_pkg supplies if_reason_e (IF_FENCE_I used here).
- Add to muntjac_pkg: localparam ATP_MODE_BARE=4'd0 and the state typedef ifetch_lb_state_e {IDLE, HIT, FAULT, MREQ, MWAIT, MRESP}.
- One natural sub-module: muntjac_ifetch_linebuf_store. It holds the line data, tag and valid; it has a beat write port, a word read mux and an invalidate input.
- The FSM stays in the top.

Test Plan:
- Cold miss at pc=0x1000, bare atp, memory beats 0x..0013_0000_0093 etc., no error:
  - mem_req_addr_o=0x1000 asserted once; 4 beats consumed.
  - resp_valid_o exactly one cycle after the last beat, resp_instr_o=0x00000093, exception=0.
- Follow-up hits at pc=0x1004, 0x100A, 0x101C:
  - Each responds 1 cycle later with the correct 32-bit word; mem_req_valid_o stays 0.
- req_reason_i=IF_FENCE_I at pc=0x1004 after the line is filled:
  - A refill is issued to 0x1000, and the response uses the new memory data.
- Error on beat 2 of a refill for pc=0x2000:
  - resp_exception_o=1, resp_instr_o=0.
  - The next request to 0x2000 misses again.
- req_atp_i=0x8000_0000_0000_1234:
  - Response one cycle later with resp_exception_o=1; no memory request.
- Assert rst_i during MWAIT with beat 1 received, release, then request pc=0x1000:
  - Full refill is issued; no stale response pulse occurs after reset.
